// File: rtl/subtractor_n_bit_seq.sv
// Bit-serial ripple-borrow subtractor: one difference bit per clock.
// Result, borrow and signed overflow are reported with a one-cycle done pulse.
module subtractor_n_bit_seq #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] in_a,
    input  logic [size-1:0] in_b,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] out,
    output logic            bout,
    output logic            ovf
);

    localparam int IW = (size > 1) ? $clog2(size) : 1;
    localparam logic [IW-1:0] LAST = IW'(size - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [size-1:0] a_r;
    logic [size-1:0] b_r;
    logic [size-1:0] res;
    logic [size-1:0] res_n;
    logic            br;
    logic            ai;
    logic            bi;
    logic            d;
    logic            br_n;

    // One ripple-borrow cell, applied to bit idx of the latched operands
    always_comb begin
        ai         = a_r[idx];
        bi         = b_r[idx];
        d          = ai ^ bi ^ br;
        br_n       = (~ai & bi) | (~(ai ^ bi) & br);
        res_n      = res;
        res_n[idx] = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        res   <= '0;
                        br    <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res <= res_n;
                    br  <= br_n;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        // d is the msb here, so overflow uses it directly
                        out   <= res_n;
                        bout  <= br_n;
                        ovf   <= (a_r[size-1] != b_r[size-1]) &
                                 (d != a_r[size-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_n_bit_seq.sv
// Directed and exhaustive checks of the bit-serial subtractor
// at widths 4 (main), 1 and 8.
module tb_subtractor_n_bit_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_v = '0;
    logic [7:0] b_v = '0;
    logic       s1 = 1'b0;
    logic       s4 = 1'b0;
    logic       s8 = 1'b0;

    logic [0:0] o1;
    logic [3:0] o4;
    logic [7:0] o8;
    logic busy1, done1, bo1, ov1;
    logic busy4, done4, bo4, ov4;
    logic busy8, done8, bo8, ov8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    subtractor_n_bit_seq #(.size(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4),
        .in_a(a_v[3:0]), .in_b(b_v[3:0]),
        .busy(busy4), .done(done4), .out(o4), .bout(bo4), .ovf(ov4)
    );

    subtractor_n_bit_seq #(.size(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1),
        .in_a(a_v[0:0]), .in_b(b_v[0:0]),
        .busy(busy1), .done(done1), .out(o1), .bout(bo1), .ovf(ov1)
    );

    subtractor_n_bit_seq #(.size(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8),
        .in_a(a_v), .in_b(b_v),
        .busy(busy8), .done(done8), .out(o8), .bout(bo8), .ovf(ov8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {diff[7:0], borrow, overflow}
    function automatic logic [9:0] ref_sub(input int w,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] m;
        logic [7:0] am, bm, d;
        logic       ov;
        m  = (9'd1 << w) - 9'd1;
        am = a & m[7:0];
        bm = b & m[7:0];
        d  = (am - bm) & m[7:0];
        ov = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
        return {d, am < bm, ov};
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1: return done1;
            4: return done4;
            default: return done8;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1: return busy1;
            4: return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [9:0] get_res(input int w);
        case (w)
            1: return {7'd0, o1, bo1, ov1};
            4: return {4'd0, o4, bo4, ov4};
            default: return {o8, bo8, ov8};
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1: s1 = v;
            4: s4 = v;
            default: s8 = v;
        endcase
    endtask

    task automatic run_op(input int w, input logic [7:0] a,
                          input logic [7:0] b, output logic [9:0] r,
                          output int lat, output int bc);
        @(negedge clk);
        a_v = a;
        b_v = b;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        lat = 0;
        bc  = 0;
        while (!get_done(w) && lat < 20) begin
            if (get_busy(w)) bc++;
            @(negedge clk);
            lat++;
        end
        r = get_res(w);
    endtask

    initial begin
        logic [9:0] r;
        logic [9:0] held;
        logic [7:0] ra, rb;
        int lat, bc, dc, n, bad_lat;
        logic stable;
        int t[$];

        repeat (3) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_res4", get_res(4), 0);
        check("rst_res8", get_res(8), 0);
        rst = 1'b0;

        run_op(4, 8'h7, 8'h3, r, lat, bc);
        check("t1_res", r, {8'h04, 1'b0, 1'b0});
        check("t1_lat", lat, 4);
        check("t1_busy", bc, 4);
        check("t1_busy_done", busy4, 0);
        @(negedge clk);
        check("t1_pulse", done4, 0);

        run_op(4, 8'h3, 8'h7, r, lat, bc);
        check("t2_res", r, {8'h0C, 1'b1, 1'b0});
        run_op(4, 8'h8, 8'h1, r, lat, bc);
        check("t3_neg", r, {8'h07, 1'b0, 1'b1});
        run_op(4, 8'h7, 8'hF, r, lat, bc);
        check("t3_pos", r, {8'h08, 1'b1, 1'b1});

        @(negedge clk);
        a_v = 8'h9;
        b_v = 8'h2;
        s4  = 1'b1;
        @(negedge clk);
        a_v = 8'hF;
        b_v = 8'h0;
        @(negedge clk);
        @(negedge clk);
        s4 = 1'b0;
        n  = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_lat", n, 2);
        held = get_res(4);
        check("t4_res", held, {8'h07, 1'b0, 1'b1});
        dc     = 0;
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done4) dc++;
            if (get_res(4) != held) stable = 1'b0;
        end
        check("t4_no_extra_done", dc, 0);
        check("t4_stable", stable, 1);

        @(negedge clk);
        a_v = 8'h5;
        b_v = 8'h1;
        s4  = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_hold_run", get_res(4), {8'h07, 1'b0, 1'b1});
        check("t5_busy_pre", busy4, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy4, 0);
        check("t5_res", get_res(4), 0);
        @(negedge clk);
        rst = 1'b0;
        dc  = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) dc++;
        end
        check("t5_no_done", dc, 0);
        run_op(4, 8'h0, 8'h0, r, lat, bc);
        check("t5_zero", r, 0);
        check("t5_lat", lat, 4);

        @(negedge clk);
        a_v = 8'h7;
        b_v = 8'h3;
        s4  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done4) begin
                t.push_back(c);
                check("t6_res", get_res(4), {8'h04, 1'b0, 1'b0});
            end
        end
        s4 = 1'b0;
        check("t6_count", t.size() >= 3, 1);
        check("t6_gap1", t.size() >= 2 ? t[1] - t[0] : 0, 6);
        check("t6_gap2", t.size() >= 3 ? t[2] - t[1] : 0, 6);
        repeat (8) @(negedge clk);

        bad_lat = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4, 8'(a), 8'(b), r, lat, bc);
                if (lat != 4) bad_lat++;
                check($sformatf("ex4 a=%0h b=%0h", a, b), r,
                      ref_sub(4, 8'(a), 8'(b)));
            end
        end
        check("ex4_lat", bad_lat, 0);

        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                run_op(1, 8'(a), 8'(b), r, lat, bc);
                check($sformatf("w1 a=%0d b=%0d", a, b), r,
                      ref_sub(1, 8'(a), 8'(b)));
                check("w1_lat", lat, 1);
            end
        end
        run_op(1, 8'h0, 8'h1, r, lat, bc);
        check("w1_0m1", r, {8'h01, 1'b1, 1'b1});

        run_op(8, 8'h80, 8'h01, r, lat, bc);
        check("w8_ovf", r, {8'h7F, 1'b0, 1'b1});
        check("w8_lat", lat, 8);
        run_op(8, 8'h00, 8'hFF, r, lat, bc);
        check("w8_borrow", r, {8'h01, 1'b1, 1'b0});
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            run_op(8, ra, rb, r, lat, bc);
            check($sformatf("w8 a=%0h b=%0h", ra, rb), r,
                  ref_sub(8, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subtractor_n_bit_seq.md
Name: subtractor_n_bit_seq

Overview:
Bit-serial, multi-cycle N-bit subtractor. It computes `in_a - in_b` one bit per clock using a ripple-borrow cell, which is the inverse operation of the combinational ripple-carry adder in the ALU. It is used as the area-cheap SUB/CMP path for the ALU's multi-cycle operations. Operands are accepted on a start handshake, and the result is reported with a one-cycle done pulse.

Parameters:
- size, 4: operand and result width in bits. Must be at least 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous and active-high.
- start, input, 1: request a subtraction. Sampled only in the IDLE state.
- in_a, input, size: minuend. Sampled on the edge where start is accepted.
- in_b, input, size: subtrahend. Sampled on the edge where start is accepted.
- busy, output, 1: high while an operation is in progress (RUN state).
- done, output, 1: one-cycle pulse meaning out, bout and ovf hold a new result.
- out, output, size: difference, `in_a - in_b` mod 2^size.
- bout, output, 1: borrow out. 1 if and only if in_a < in_b (unsigned).
- ovf, output, 1: two's-complement overflow of the signed subtraction.

Behaviour:
- Reset (async assert on rst=1):
  - State goes to IDLE; bit counter, operand registers and borrow are cleared.
  - Outputs are all 0: busy, done, out, bout, ovf.
  - Release is synchronous to clk.
- States are IDLE, RUN and DONE.
- IDLE:
  - If start=1 at edge E0: latch in_a and in_b, set borrow to 0, set bit index to 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1 throughout.
  - At each edge Ek (k = 1..size), bit i = k-1 is processed:
    - `d[i] = a[i] ^ b[i] ^ br`
    - `br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)`
    - d[i] is written into an internal result register, not into out directly.
  - At edge E(size), the last bit is processed and:
    - out is loaded with the full difference.
    - bout is loaded with the final borrow.
    - ovf is loaded with `(a[msb] != b[msb]) & (d[msb] != a[msb])`.
    - State goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge goes to IDLE unconditionally; done returns to 0.
- Latency: done is high in the cycle following edge E(size), i.e. size edges after start is accepted. Throughput is one operation per size+2 cycles.
- start is ignored while in RUN or DONE. There is no queuing, and operand changes during RUN have no effect.
- out, bout and ovf hold their last result until the next completion. They do not change at start acceptance or during RUN.
- rst asserted mid-operation aborts the operation: no done pulse, and outputs are cleared to 0.
- size=1 is legal: exactly one RUN cycle.
- All arithmetic is unsigned mod 2^size. ovf is the only signed interpretation.

Test Plan (size=4 unless stated):
1. Basic: a=7, b=3, start pulse -> done exactly 4 edges after acceptance; out=4, bout=0, ovf=0; busy high for 4 cycles.
2. Borrow: a=3, b=7 -> out=0xC, bout=1, ovf=0.
3. Signed overflow, negative: a=0x8, b=0x1 (-8 - 1) -> out=0x7, bout=0, ovf=1. Signed overflow, positive: a=0x7, b=0xF (7 - (-1)) -> out=0x8, bout=1, ovf=1.
4. Ignored start: start re-asserted with a=0xF, b=0x0 during RUN -> first result unaffected, no extra done; outputs held stable from completion until the next completion.
5. Reset mid-op: rst pulsed at RUN bit 2 (async, mid-cycle) -> immediate busy=0 and out=0; no done; the next start (a=0, b=0) gives out=0, bout=0, ovf=0.
6. Back-to-back and exhaustive: start held high continuously -> operations complete every 6 cycles. Exhaustive sweep of all 256 a/b pairs against a reference model; repeat with size=1 and size=8 (random).
